// File: rtl/uart_tx.sv
// uart_tx - 8N1 serial transmitter with a small transmit FIFO.
//
// Bytes are queued through a valid/ready push interface and sent LSB first,
// framed by one start bit (0) and one stop bit (1), each bit lasting
// CLKS_PER_BIT clocks. Queued bytes follow each other with no idle gap.
//
// Parameters
//   CLKS_PER_BIT : clocks per serial bit, 2..65535
//   FIFO_DEPTH   : transmit FIFO entries, power of two, 2..16
//
// Ports
//   i_clk          : clock, all logic on the rising edge
//   i_reset        : synchronous active-high reset
//   i_tx_data      : byte to enqueue
//   i_tx_valid     : i_tx_data valid this cycle
//   o_tx_ready     : FIFO can accept a byte this cycle
//   o_tx_serial    : serial line, idle high, driven from a flop
//   o_tx_busy      : transmitter not idle
//   o_tx_done      : one-cycle pulse on the last cycle of each stop bit
//   o_fifo_count   : bytes queued, not counting the byte being shifted
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | line high, waiting for a queued byte
// START | start bit (0) on the line
// DATA  | data bit r_bit on the line, LSB first
// STOP  | stop bit (1); last cycle pulses done and may chain a frame

module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic [7:0]                    i_tx_data,
  input  logic                          i_tx_valid,
  output logic                          o_tx_ready,
  output logic                          o_tx_serial,
  output logic                          o_tx_busy,
  output logic                          o_tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [15:0]   LP_RELOAD = 16'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] LP_DEPTH  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  state_t        r_state;
  logic [15:0]   r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_serial;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  state_t        w_state_nxt;
  logic [15:0]   w_cnt_nxt;
  logic [2:0]    w_bit_nxt;
  logic [7:0]    w_shift_nxt;
  logic          w_serial_nxt;
  logic          w_pop;
  logic          w_push;
  logic          w_done;
  logic          w_cnt_tc;
  logic          w_fifo_nempty;
  logic [7:0]    w_head;

  // Ready depends only on the registered count, never on i_tx_valid.
  assign o_tx_ready    = (r_count < LP_DEPTH);
  assign w_push        = i_tx_valid && o_tx_ready && !i_reset;
  // Registered count: a byte pushed this cycle is not visible to the pop
  // logic until the next cycle.
  assign w_fifo_nempty = (r_count != '0);
  assign w_head        = r_mem[r_rd_ptr];
  assign w_cnt_tc      = (r_cnt == 16'd0);

  // ---------------------------------------------------------------- FIFO
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_tx_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // ----------------------------------------------------------------- FSM
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_serial <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_bit    <= w_bit_nxt;
      r_shift  <= w_shift_nxt;
      r_serial <= w_serial_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_pop       = 1'b0;
    w_done      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_fifo_nempty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_head;
          w_cnt_nxt   = LP_RELOAD;
          w_state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (w_cnt_tc) begin
          w_cnt_nxt   = LP_RELOAD;
          w_bit_nxt   = 3'd0;
          w_state_nxt = ST_DATA;
        end else begin
          w_cnt_nxt = r_cnt - 16'd1;
        end
      end
      ST_DATA: begin
        if (w_cnt_tc) begin
          w_shift_nxt = {1'b0, r_shift[7:1]};
          w_cnt_nxt   = LP_RELOAD;
          w_bit_nxt   = r_bit + 3'd1;
          if (r_bit == 3'd7) w_state_nxt = ST_STOP;
        end else begin
          w_cnt_nxt = r_cnt - 16'd1;
        end
      end
      ST_STOP: begin
        if (w_cnt_tc) begin
          w_done = 1'b1;
          // Chain straight into the next frame when a byte is waiting.
          if (w_fifo_nempty) begin
            w_pop       = 1'b1;
            w_shift_nxt = w_head;
            w_cnt_nxt   = LP_RELOAD;
            w_state_nxt = ST_START;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt - 16'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // The line level is derived from the next state so the flop shows each
  // bit in the same cycle the state register enters it.
  always_comb begin
    w_serial_nxt = 1'b1;
    case (w_state_nxt)
      ST_START: w_serial_nxt = 1'b0;
      ST_DATA:  w_serial_nxt = w_shift_nxt[0];
      default:  w_serial_nxt = 1'b1;
    endcase
  end

  assign o_tx_serial  = r_serial;
  assign o_tx_busy    = (r_state != ST_IDLE);
  assign o_tx_done    = w_done;
  assign o_fifo_count = r_count;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx - self-checking bench for uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4).
// Accepted bytes go into a scoreboard queue; a line decoder rebuilds each
// frame from o_tx_serial and compares it against the head of the queue.

module tb_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_serial;
  logic       tx_busy;
  logic       tx_done;
  logic [2:0] fifo_count;

  always #5 clk = ~clk;

  uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_tx_data    (tx_data),
    .i_tx_valid   (tx_valid),
    .o_tx_ready   (tx_ready),
    .o_tx_serial  (tx_serial),
    .o_tx_busy    (tx_busy),
    .o_tx_done    (tx_done),
    .o_fifo_count (fifo_count)
  );

  int         n_tests   = 0;
  int         n_fail    = 0;
  logic [7:0] sb_q[$];
  int         done_cnt  = 0;
  int         frames_rx = 0;
  int         max_cnt   = 0;

  bit         mon_busy  = 1'b0;
  int         mon_cnt   = 0;
  logic [7:0] mon_byte  = 8'h00;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b, input bit exp_acc);
    tx_data  = b;
    tx_valid = 1'b1;
    check_val("push_ready", {31'd0, tx_ready}, {31'd0, exp_acc});
    if (exp_acc) sb_q.push_back(b);
    tick();
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
  endtask

  task automatic wait_done(input string tag, input int target, input int limit);
    int cyc;
    cyc = 0;
    while (done_cnt < target && cyc < limit) begin
      tick();
      cyc++;
    end
    check_val(tag, done_cnt, target);
  endtask

  // Line decoder and event counters, sampled mid-cycle.
  always @(negedge clk) begin
    int idx;
    logic [31:0] exp;
    if (tx_done) done_cnt++;
    if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
    if (reset) begin
      mon_busy = 1'b0;
    end else if (!mon_busy) begin
      if (tx_serial == 1'b0) begin
        mon_busy = 1'b1;
        mon_cnt  = 0;
      end
    end else begin
      mon_cnt++;
      if (mon_cnt % CPB == CPB / 2) begin
        idx = mon_cnt / CPB;
        if (idx >= 1 && idx <= 8) mon_byte[idx-1] = tx_serial;
        if (idx == 9) begin
          check_val("rx_stop", {31'd0, tx_serial}, 32'd1);
          frames_rx++;
          exp = (sb_q.size() > 0) ? {24'd0, sb_q.pop_front()} : 32'h100;
          check_val("rx_byte", {24'd0, mon_byte}, exp);
          mon_busy = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] frame;
    int d0;
    int cyc;
    int gaps;
    int lows;

    reset    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (3) tick();
    check_val("rst_serial", {31'd0, tx_serial}, 32'd1);
    check_val("rst_busy",   {31'd0, tx_busy},   32'd0);
    check_val("rst_done",   {31'd0, tx_done},   32'd0);
    check_val("rst_count",  {29'd0, fifo_count}, 32'd0);
    check_val("rst_ready",  {31'd0, tx_ready},  32'd1);
    reset = 1'b0;
    tick();

    // Single byte: latency, bit pattern, done pulse.
    push_byte(8'hA5, 1'b1);
    check_val("lat_n1_serial", {31'd0, tx_serial}, 32'd1);
    check_val("lat_n1_count",  {29'd0, fifo_count}, 32'd1);
    tick();
    check_val("lat_n2_busy",   {31'd0, tx_busy},   32'd1);
    check_val("lat_n2_count",  {29'd0, fifo_count}, 32'd0);
    frame = {1'b1, 8'hA5, 1'b0};
    for (int c = 1; c <= 10 * CPB; c++) begin
      check_val("t1_serial", {31'd0, tx_serial}, {31'd0, frame[(c-1)/CPB]});
      check_val("t1_done",   {31'd0, tx_done},   (c == 10 * CPB) ? 32'd1 : 32'd0);
      tick();
    end
    check_val("t1_busy_after",   {31'd0, tx_busy},   32'd0);
    check_val("t1_serial_after", {31'd0, tx_serial}, 32'd1);
    check_val("t1_done_cnt",     done_cnt, 1);

    // Five consecutive pushes: fill, then back-to-back frames.
    d0 = done_cnt;
    for (int b = 1; b <= 5; b++) push_byte(8'(b), 1'b1);
    check_val("t2_count_full", {29'd0, fifo_count}, 32'd4);
    check_val("t2_ready_full", {31'd0, tx_ready},   32'd0);
    cyc  = 0;
    gaps = 0;
    while (cyc < 400) begin
      tick();
      cyc++;
      if (done_cnt >= d0 + 5) break;
      if (!tx_busy) gaps++;
    end
    check_val("t2_done_cnt", done_cnt, d0 + 5);
    check_val("t2_cycles",   cyc, 197);
    check_val("t2_gaps",     gaps, 0);
    check_val("t2_sb_empty", sb_q.size(), 0);

    // Push against a full FIFO on the cycle it pops.
    d0 = done_cnt;
    for (int b = 0; b < 5; b++) push_byte(8'(8'h21 + b), 1'b1);
    repeat (36) tick();
    check_val("t3_in_stop",    {31'd0, tx_done},    32'd1);
    check_val("t3_count_pre",  {29'd0, fifo_count}, 32'd4);
    push_byte(8'h77, 1'b0);
    check_val("t3_count_post", {29'd0, fifo_count}, 32'd3);
    wait_done("t3_done_cnt", d0 + 5, 400);
    tick();
    check_val("t3_sb_empty", sb_q.size(), 0);
    check_val("t3_count_end", {29'd0, fifo_count}, 32'd0);

    // Reset during data bit 3 of 0xFF with two bytes queued.
    push_byte(8'hFF, 1'b1);
    push_byte(8'hAB, 1'b1);
    push_byte(8'hCD, 1'b1);
    repeat (16) tick();
    check_val("t4_pre_count",  {29'd0, fifo_count}, 32'd2);
    check_val("t4_pre_busy",   {31'd0, tx_busy},    32'd1);
    sb_q.delete();
    d0       = done_cnt;
    reset    = 1'b1;
    tx_valid = 1'b1;
    tx_data  = 8'h99;
    tick();
    reset    = 1'b0;
    tx_valid = 1'b0;
    check_val("t4_serial", {31'd0, tx_serial},  32'd1);
    check_val("t4_count",  {29'd0, fifo_count}, 32'd0);
    check_val("t4_busy",   {31'd0, tx_busy},    32'd0);
    check_val("t4_ready",  {31'd0, tx_ready},   32'd1);
    lows = 0;
    repeat (100) begin
      tick();
      if (!tx_serial) lows++;
    end
    check_val("t4_line_low", lows, 0);
    check_val("t4_no_done",  done_cnt, d0);

    // Ten single bytes to exercise pointer wrap.
    max_cnt = 0;
    d0      = done_cnt;
    for (int i = 0; i < 10; i++) begin
      push_byte(8'(8'h10 + i), 1'b1);
      wait_done("t5_done", d0 + i + 1, 60);
    end
    tick();
    check_val("t5_max_count", max_cnt, 1);
    check_val("t5_sb_empty",  sb_q.size(), 0);
    check_val("frames_total", frames_rx, 21);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
